// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Self-timed seven-segment scan multiplexer with a programmable
//            window onto a packed BCD bus, per-frame snapshot and optional
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_NIBBLES = 6,
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BASE_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4*NUM_NIBBLES-1:0] count,
    input  logic [BASE_W-1:0]        win_base,
    input  logic                     blank_lz,
    output logic [DIGITS-1:0]        an,
    output logic [3:0]               x,
    output logic                     blank,
    output logic                     frame_tick
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [BASE_W-1:0]  c_MAX_BASE = BASE_W'(NUM_NIBBLES - DIGITS);

    logic [c_DIV_W-1:0]       r_div;
    logic [c_IDX_W-1:0]       r_idx;
    logic [4*NUM_NIBBLES-1:0] r_snap;
    logic [BASE_W-1:0]        r_base;
    logic [DIGITS-1:0]        r_an;
    logic [3:0]               r_x;
    logic                     r_blank;
    logic                     r_frame_tick;

    logic                     w_tick;
    logic [c_IDX_W-1:0]       w_idx_n;
    logic                     w_frame;
    logic [4*NUM_NIBBLES-1:0] w_snap;
    logic [BASE_W-1:0]        w_base;
    logic [3:0]               w_x_n;
    logic                     w_all_zero;
    logic                     w_blank_n;
    logic [DIGITS-1:0]        w_an_n;

    // Nibble p of a packed bus; positions past the top read as zero.
    function automatic logic [3:0] nib(input logic [4*NUM_NIBBLES-1:0] s, input int p);
        nib = 4'd0;
        for (int k = 0; k < NUM_NIBBLES; k++) begin
            if (k == p) nib = s[4*k +: 4];
        end
    endfunction

    // On a frame-start tick the new slot must already see the fresh capture.
    always_comb begin
        w_tick     = (r_div == c_DIV_LAST);
        w_idx_n    = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        w_frame    = (w_idx_n == '0);
        w_snap     = w_frame ? count : r_snap;
        w_base     = w_frame ? ((win_base > c_MAX_BASE) ? c_MAX_BASE : win_base) : r_base;
        w_x_n      = nib(w_snap, int'(w_base) + int'(w_idx_n));
        w_all_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(w_idx_n) && nib(w_snap, int'(w_base) + j) != 4'd0)
                w_all_zero = 1'b0;
        end
        w_blank_n  = blank_lz && (w_idx_n != '0) && w_all_zero;
        w_an_n     = ~(DIGITS'(1) << w_idx_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div        <= '0;
            r_idx        <= c_IDX_LAST;
            r_snap       <= '0;
            r_base       <= '0;
            r_an         <= '1;
            r_x          <= 4'd0;
            r_blank      <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (w_tick) begin
                r_div <= '0;
                r_idx <= w_idx_n;
                if (w_frame) begin
                    r_snap       <= count;
                    r_base       <= w_base;
                    r_frame_tick <= 1'b1;
                end
                if (w_blank_n) begin
                    r_an    <= '1;
                    r_x     <= 4'd0;
                    r_blank <= 1'b1;
                end else begin
                    r_an    <= w_an_n;
                    r_x     <= w_x_n;
                    r_blank <= 1'b0;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign x          = r_x;
    assign blank      = r_blank;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Brief    : Directed self-checking bench for seg_scan_mux (6 nibbles,
//            4 digits, 4-cycle digit period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic [23:0] count;
    logic [2:0]  win_base;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  x;
    logic        blank;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_mux #(
        .NUM_NIBBLES (6),
        .DIGITS      (4),
        .SCAN_DIV    (4),
        .BASE_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .win_base   (win_base),
        .blank_lz   (blank_lz),
        .an         (an),
        .x          (x),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] e_an, input logic [3:0] e_x,
                        input logic e_blank, input logic e_ft);
        chk({tag, ".an"},    32'(an),         32'(e_an));
        chk({tag, ".x"},     32'(x),          32'(e_x));
        chk({tag, ".blank"}, 32'(blank),      32'(e_blank));
        chk({tag, ".ft"},    32'(frame_tick), 32'(e_ft));
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        count    = 24'h123456;
        win_base = 3'd0;
        blank_lz = 1'b0;

        // 1. reset and first lit digit
        edges(3);
        slot("rst_hold", 4'b1111, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        edges(3);
        slot("pre_first", 4'b1111, 4'h0, 1'b0, 1'b0);
        edges(1);
        slot("first_d0", 4'b1110, 4'h6, 1'b0, 1'b1);
        edges(1);
        slot("d0_hold", 4'b1110, 4'h6, 1'b0, 1'b0);

        // 2. scan order and frame wrap
        edges(3);  slot("s_d1", 4'b1101, 4'h5, 1'b0, 1'b0);
        edges(3);  slot("s_d1_hold", 4'b1101, 4'h5, 1'b0, 1'b0);
        edges(1);  slot("s_d2", 4'b1011, 4'h4, 1'b0, 1'b0);
        edges(4);  slot("s_d3", 4'b0111, 4'h3, 1'b0, 1'b0);
        edges(4);  slot("s_wrap", 4'b1110, 4'h6, 1'b0, 1'b1);

        // 3. window change while digit 1 is lit
        edges(4);  slot("w_d1", 4'b1101, 4'h5, 1'b0, 1'b0);
        win_base = 3'd2;
        edges(4);  slot("w_d2", 4'b1011, 4'h4, 1'b0, 1'b0);
        edges(4);  slot("w_d3", 4'b0111, 4'h3, 1'b0, 1'b0);
        edges(4);  slot("w2_d0", 4'b1110, 4'h4, 1'b0, 1'b1);
        win_base = 3'd0;
        edges(4);  slot("w2_d1", 4'b1101, 4'h3, 1'b0, 1'b0);
        edges(4);  slot("w2_d2", 4'b1011, 4'h2, 1'b0, 1'b0);
        edges(4);  slot("w2_d3", 4'b0111, 4'h1, 1'b0, 1'b0);

        // 4. count change during digit 2
        edges(4);  slot("c_d0", 4'b1110, 4'h6, 1'b0, 1'b1);
        edges(4);  slot("c_d1", 4'b1101, 4'h5, 1'b0, 1'b0);
        edges(4);  slot("c_d2", 4'b1011, 4'h4, 1'b0, 1'b0);
        count = 24'h999999;
        edges(4);  slot("c_d3", 4'b0111, 4'h3, 1'b0, 1'b0);
        edges(4);  slot("c9_d0", 4'b1110, 4'h9, 1'b0, 1'b1);
        edges(4);  slot("c9_d1", 4'b1101, 4'h9, 1'b0, 1'b0);
        edges(4);  slot("c9_d2", 4'b1011, 4'h9, 1'b0, 1'b0);
        edges(4);  slot("c9_d3", 4'b0111, 4'h9, 1'b0, 1'b0);

        // 5. leading-zero blanking
        count    = 24'h000007;
        blank_lz = 1'b1;
        edges(4);  slot("b7_d0", 4'b1110, 4'h7, 1'b0, 1'b1);
        edges(4);  slot("b7_d1", 4'b1111, 4'h0, 1'b1, 1'b0);
        edges(4);  slot("b7_d2", 4'b1111, 4'h0, 1'b1, 1'b0);
        edges(4);  slot("b7_d3", 4'b1111, 4'h0, 1'b1, 1'b0);
        count = 24'h000000;
        edges(4);  slot("b0_d0", 4'b1110, 4'h0, 1'b0, 1'b1);
        edges(4);  slot("b0_d1", 4'b1111, 4'h0, 1'b1, 1'b0);
        edges(8);  slot("b0_d3", 4'b1111, 4'h0, 1'b1, 1'b0);
        count = 24'h000100;
        edges(4);  slot("bh_d0", 4'b1110, 4'h0, 1'b0, 1'b1);
        edges(4);  slot("bh_d1", 4'b1101, 4'h0, 1'b0, 1'b0);
        edges(4);  slot("bh_d2", 4'b1011, 4'h1, 1'b0, 1'b0);
        edges(4);  slot("bh_d3", 4'b1111, 4'h0, 1'b1, 1'b0);

        // 6. clamped window and asynchronous reset
        blank_lz = 1'b0;
        count    = 24'h123456;
        win_base = 3'd7;
        edges(4);  slot("k_d0", 4'b1110, 4'h4, 1'b0, 1'b1);
        edges(4);  slot("k_d1", 4'b1101, 4'h3, 1'b0, 1'b0);
        edges(4);  slot("k_d2", 4'b1011, 4'h2, 1'b0, 1'b0);
        edges(4);  slot("k_d3", 4'b0111, 4'h1, 1'b0, 1'b0);
        edges(4);  slot("k2_d0", 4'b1110, 4'h4, 1'b0, 1'b1);
        edges(2);
        #2;
        rst = 1'b0;
        #1;
        slot("async_rst", 4'b1111, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        edges(3);  slot("r_pre", 4'b1111, 4'h0, 1'b0, 1'b0);
        edges(1);  slot("r_d0", 4'b1110, 4'h4, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
